// File: rtl/cpu_sequencer.sv
// cpu_sequencer: single-clock fetch/decode/mem-wait/execute sequencer with run, halt, step and breakpoint control
module cpu_sequencer #(
  parameter int              DATA_W       = 16,
  parameter int              PC_W         = 8,
  parameter int              MEM_LAT      = 1,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0,
  parameter bit              START_RUN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              mem_req,
  input  logic              jump_en,
  input  logic [PC_W-1:0]   jump_target,
  output logic [PC_W-1:0]   rom_addr,
  output logic              rom_en,
  output logic [DATA_W-1:0] instr_out,
  output logic              mem_rd_en,
  output logic              exec_en,
  output logic [PC_W-1:0]   pc,
  output logic [2:0]        state,
  output logic              halted,
  output logic [15:0]       retired
);
  typedef enum logic [2:0] {
    S_HALT     = 3'd0,
    S_FETCH    = 3'd1,
    S_ROM_WAIT = 3'd2,
    S_DECODE   = 3'd3,
    S_MEM      = 3'd4,
    S_EXEC     = 3'd5
  } state_e;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT > 0 ? MEM_LAT - 1 : 0);
  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc_next;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [15:0]       ret_q, ret_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              resume_q, resume_d, step_q, step_d, hreq_q, hreq_d;
  logic              bp_hit, stop;
  assign pc_next = jump_en ? jump_target : pc_q + 1'b1;
  // The first instruction after leaving HALT never re-triggers the breakpoint.
  assign bp_hit  = bp_en && pc_next == bp_addr && !resume_q;
  assign stop    = !run || hreq_q || halt_req || step_q || bp_hit;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ret_d    = ret_q;
    cnt_d    = cnt_q;
    resume_d = resume_q;
    step_d   = step_q;
    hreq_d   = state_q != S_HALT && (hreq_q || halt_req);
    case (state_q)
      S_HALT: begin
        state_d  = (run || step) ? S_FETCH : S_HALT;
        resume_d = run || step;
        step_d   = !run && step;
      end
      S_FETCH:    state_d = S_ROM_WAIT;
      S_ROM_WAIT: begin
        instr_d = instr_in;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = (mem_req && MEM_LAT > 0) ? S_MEM : S_EXEC;
        cnt_d   = LAT_M1;
      end
      S_MEM: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q == 4'd0 ? S_EXEC : S_MEM;
      end
      S_EXEC: begin
        pc_d     = pc_next;
        ret_d    = ret_q + 16'd1;
        resume_d = 1'b0;
        step_d   = 1'b0;
        hreq_d   = 1'b0;
        state_d  = stop ? S_HALT : S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= (START_RUN && !(bp_en && bp_addr == RESET_VECTOR)) ? S_FETCH : S_HALT;
      pc_q     <= RESET_VECTOR;
      instr_q  <= '0;
      ret_q    <= '0;
      cnt_q    <= '0;
      resume_q <= 1'b0;
      step_q   <= 1'b0;
      hreq_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ret_q    <= ret_d;
      cnt_q    <= cnt_d;
      resume_q <= resume_d;
      step_q   <= step_d;
      hreq_q   <= hreq_d;
    end
  end
  // Strobes drop as soon as reset is asserted so an aborted instruction never commits.
  assign rom_en    = !rst && state_q == S_FETCH;
  assign mem_rd_en = !rst && state_q == S_MEM;
  assign exec_en   = !rst && state_q == S_EXEC;
  assign rom_addr  = pc_q;
  assign pc        = pc_q;
  assign instr_out = instr_q;
  assign state     = state_q;
  assign halted    = state_q == S_HALT;
  assign retired   = ret_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: vector table plus EXEC scoreboard for cpu_sequencer (MEM_LAT=3, START_RUN=1)
module tb_cpu_sequencer;
  localparam int PC_W = 8;
  localparam int DW   = 16;
  logic            clk = 1'b0;
  logic            rst = 1'b1, run = 1'b1, step = 1'b0, halt_req = 1'b0, bp_en = 1'b0;
  logic            mem_req = 1'b0, jump_en = 1'b0;
  logic [PC_W-1:0] bp_addr = '0, jump_target = '0;
  logic [PC_W-1:0] rom_addr, pc;
  logic [DW-1:0]   instr_in, instr_out;
  logic            rom_en, mem_rd_en, exec_en, halted;
  logic [2:0]      state;
  logic [15:0]     retired;
  int              checks = 0, errors = 0, n_exec = 0, base = 0, c = 0, m = 0;
  logic [PC_W-1:0] mpc;
  logic [15:0]     mret;
  typedef struct {
    logic [PC_W-1:0] pc;
    logic [DW-1:0]   ins;
    logic [15:0]     ret;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  typedef struct {
    logic            mem;
    logic            jmp;
    logic [PC_W-1:0] tgt;
    int              lat;
    int              mcy;
    logic [PC_W-1:0] npc;
  } vec_t;
  vec_t vt[6];

  cpu_sequencer #(.DATA_W(DW), .PC_W(PC_W), .MEM_LAT(3), .RESET_VECTOR(8'h00), .START_RUN(1'b1)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .halt_req(halt_req), .bp_en(bp_en),
    .bp_addr(bp_addr), .instr_in(instr_in), .mem_req(mem_req), .jump_en(jump_en),
    .jump_target(jump_target), .rom_addr(rom_addr), .rom_en(rom_en), .instr_out(instr_out),
    .mem_rd_en(mem_rd_en), .exec_en(exec_en), .pc(pc), .state(state), .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rom_en) instr_in <= {~rom_addr, rom_addr};

  function automatic logic [DW-1:0] rw(input logic [PC_W-1:0] a);
    return {~a, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [PC_W-1:0] p, input logic [15:0] r);
    exp_q.push_back('{p, rw(p), r});
  endtask

  always @(negedge clk) if (exec_en === 1'b1) begin
    n_exec++;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_exec: got pc %0h expected no commit", pc);
    end else begin
      e = exp_q.pop_front();
      chk("sb_pc", 32'(pc), 32'(e.pc));
      chk("sb_instr", 32'(instr_out), 32'(e.ins));
      chk("sb_retired", 32'(retired), 32'(e.ret));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b0, 1'b0, 8'h00, 4, 0, 8'h0B};
    vt[1] = '{1'b1, 1'b0, 8'h00, 7, 3, 8'h0C};
    vt[2] = '{1'b0, 1'b1, 8'hFF, 4, 0, 8'hFF};
    vt[3] = '{1'b0, 1'b0, 8'h00, 4, 0, 8'h00};
    vt[4] = '{1'b1, 1'b1, 8'h20, 7, 3, 8'h20};
    vt[5] = '{1'b0, 1'b0, 8'h00, 4, 0, 8'h21};
    for (int i = 0; i < 10; i++) push(PC_W'(i), 16'(i));
    tick(1);
    chk("rst_state", 32'(state), 32'd1);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_instr", 32'(instr_out), 32'd0);
    chk("rst_strobes", 32'({rom_en, mem_rd_en, exec_en}), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    rst = 1'b0;
    tick(40);
    chk("free_pc", 32'(pc), 32'd10);
    chk("free_retired", 32'(retired), 32'd10);
    chk("free_execs", 32'(n_exec), 32'd10);
    chk("free_state", 32'(state), 32'd1);
    mpc = 8'd10;
    mret = 16'd10;
    for (int i = 0; i < 6; i++) begin
      mem_req = vt[i].mem;
      jump_en = vt[i].jmp;
      jump_target = vt[i].tgt;
      push(mpc, mret);
      c = 1;
      m = 0;
      while (exec_en !== 1'b1 && c < 20) begin
        m += int'(mem_rd_en);
        tick(1);
        c++;
      end
      chk($sformatf("vec%0d_lat", i), 32'(c), 32'(vt[i].lat));
      chk($sformatf("vec%0d_mem_cycles", i), 32'(m), 32'(vt[i].mcy));
      tick(1);
      chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vt[i].npc));
      chk($sformatf("vec%0d_state", i), 32'(state), 32'd1);
      mpc = vt[i].npc;
      mret++;
    end
    mem_req = 1'b0;
    jump_en = 1'b0;
    chk("vec_retired", 32'(retired), 32'(mret));
    rst = 1'b1;
    bp_en = 1'b1;
    bp_addr = 8'h00;
    tick(1);
    chk("rst_bp_vector_halt", 32'(state), 32'd0);
    bp_addr = 8'h05;
    tick(1);
    chk("rst_bp_clear_fetch", 32'(state), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) push(PC_W'(i), 16'(i));
    c = 0;
    while (halted !== 1'b1 && c < 60) begin
      tick(1);
      c++;
    end
    run = 1'b0;
    chk("bp_cycles", 32'(c), 32'd20);
    chk("bp_pc", 32'(pc), 32'd5);
    chk("bp_retired", 32'(retired), 32'd5);
    tick(3);
    chk("bp_hold_halted", 32'(halted), 32'd1);
    chk("bp_hold_pc", 32'(pc), 32'd5);
    run = 1'b1;
    push(8'h05, 16'd5);
    push(8'h06, 16'd6);
    tick(5);
    chk("resume_pc", 32'(pc), 32'd6);
    chk("resume_running", 32'(halted), 32'd0);
    run = 1'b0;
    tick(4);
    chk("runstop_halted", 32'(halted), 32'd1);
    chk("runstop_pc", 32'(pc), 32'd7);
    bp_addr = 8'h40;
    run = 1'b1;
    push(8'h07, 16'd7);
    push(8'h08, 16'd8);
    tick(5);
    chk("jmp_bp_pre_pc", 32'(pc), 32'd8);
    jump_en = 1'b1;
    jump_target = 8'h40;
    tick(4);
    run = 1'b0;
    jump_en = 1'b0;
    chk("jmp_bp_halted", 32'(halted), 32'd1);
    chk("jmp_bp_pc", 32'(pc), 32'h40);
    chk("jmp_bp_retired", 32'(retired), 32'd9);
    bp_en = 1'b0;
    base = n_exec;
    step = 1'b1;
    push(8'h40, 16'd9);
    tick(1);
    step = 1'b0;
    tick(9);
    chk("step1_halted", 32'(halted), 32'd1);
    chk("step1_pc", 32'(pc), 32'h41);
    step = 1'b1;
    push(8'h41, 16'd10);
    tick(1);
    step = 1'b0;
    tick(9);
    chk("step2_halted", 32'(halted), 32'd1);
    chk("step2_pc", 32'(pc), 32'h42);
    chk("step_execs", 32'(n_exec - base), 32'd2);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    bp_en = 1'b1;
    bp_addr = 8'h44;
    run = 1'b1;
    push(8'h42, 16'd11);
    push(8'h43, 16'd12);
    tick(5);
    chk("hreq_discard_pc", 32'(pc), 32'h43);
    chk("hreq_discard_running", 32'(halted), 32'd0);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    tick(3);
    run = 1'b0;
    chk("hreq_bp_halted", 32'(halted), 32'd1);
    chk("hreq_bp_pc", 32'(pc), 32'h44);
    chk("hreq_bp_retired", 32'(retired), 32'd13);
    run = 1'b1;
    push(8'h44, 16'd13);
    push(8'h45, 16'd14);
    tick(9);
    chk("hreq_single_pc", 32'(pc), 32'h46);
    chk("hreq_single_running", 32'(halted), 32'd0);
    run = 1'b0;
    push(8'h46, 16'd15);
    tick(4);
    chk("hreq_final_halted", 32'(halted), 32'd1);
    chk("hreq_final_pc", 32'(pc), 32'h47);
    bp_en = 1'b0;
    run = 1'b1;
    mem_req = 1'b1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    base = n_exec;
    tick(4);
    chk("mem_state", 32'(state), 32'd4);
    chk("mem_rd", 32'(mem_rd_en), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("abort_state", 32'(state), 32'd1);
    chk("abort_pc", 32'(pc), 32'd0);
    chk("abort_retired", 32'(retired), 32'd0);
    chk("abort_exec_en", 32'(exec_en), 32'd0);
    chk("abort_no_commit", 32'(n_exec - base), 32'd0);
    rst = 1'b0;
    mem_req = 1'b0;
    run = 1'b0;
    push(8'h00, 16'd0);
    tick(4);
    chk("post_abort_halted", 32'(halted), 32'd1);
    chk("post_abort_pc", 32'(pc), 32'd1);
    chk("post_abort_retired", 32'(retired), 32'd1);
    chk("post_abort_execs", 32'(n_exec - base), 32'd1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
